// File: rtl/conv_index_seq_pkg.sv
// Shared widths, FSM encoding and index-tuple payload for the convolution index sequencer.
package conv_index_seq_pkg;

    localparam int unsigned SZW = 5;
    localparam int unsigned ZW  = SZW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One (i, j) tuple as presented to the MAC.
    typedef struct packed {
        logic [ZW-1:0]  z;
        logic [ZW-1:0]  y;
        logic [SZW-1:0] x;
        logic           first;
        logic           last;
    } idx_tuple_t;

endpackage

// File: rtl/conv_jrange.sv
// Valid j range for output index i: jlo = max(0, i-sz_x+1), jhi = min(i, sz_y-1).
module conv_jrange
    import conv_index_seq_pkg::*;
(
    input  logic [ZW-1:0]  i,
    input  logic [SZW-1:0] sz_x,
    input  logic [SZW-1:0] sz_y,
    output logic [ZW-1:0]  jlo,
    output logic [ZW-1:0]  jhi
);

    logic [ZW:0] ip1;
    logic [ZW:0] szx_e;

    assign ip1   = (ZW+1)'(i) + (ZW+1)'(1);
    assign szx_e = (ZW+1)'(sz_x);

    // Lower bound: x index i-j must stay below sz_x.
    always_comb begin
        jlo = '0;
        if (ip1 > szx_e) begin
            jlo = ZW'(ip1 - szx_e);
        end
    end

    // Upper bound: j must stay below sz_y and not exceed i.
    always_comb begin
        jhi = ZW'(sz_y) - ZW'(1);
        if (ZW'(sz_y) > i) begin
            jhi = i;
        end
    end

endmodule

// File: rtl/conv_index_seq.sv
// Index sequencer for the 1-D convolution core: walks all valid (i,j) of z[i] = sum_j x[i-j]*y[j].
// Optional stall counter port stall_cnt_o is built when CONV_IDX_STATS_EN is defined.
module conv_index_seq
    import conv_index_seq_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [SZW-1:0] sz_x_i,
    input  logic [SZW-1:0] sz_y_i,
    input  logic           ready_i,
    output logic           valid_o,
    output logic [SZW-1:0] x_addr_o,
    output logic [SZW-1:0] y_addr_o,
    output logic [ZW-1:0]  y_i_o,
    output logic [ZW-1:0]  z_addr_o,
    output logic           first_o,
    output logic           last_o,
    output logic           busy_o,
    output logic           done_o
`ifdef CONV_IDX_STATS_EN
    ,
    output logic [15:0]    stall_cnt_o
`endif
);

    state_t         state_q, state_d;
    logic [SZW-1:0] szx_q, szx_d;
    logic [SZW-1:0] szy_q, szy_d;
    logic [ZW-1:0]  last_i_q, last_i_d;
    idx_tuple_t     tup_q, tup_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [ZW-1:0]  jlo_cur, jhi_cur, jlo_nxt, jhi_nxt;
    logic [ZW-1:0]  y_inc, z_inc;
    logic           fire;

    assign y_inc = tup_q.y + ZW'(1);
    assign z_inc = tup_q.z + ZW'(1);
    assign fire  = valid_q & ready_i;

    conv_jrange u_jr_cur (
        .i    (tup_q.z),
        .sz_x (szx_q),
        .sz_y (szy_q),
        .jlo  (jlo_cur),
        .jhi  (jhi_cur)
    );

    conv_jrange u_jr_nxt (
        .i    (z_inc),
        .sz_x (szx_q),
        .sz_y (szy_q),
        .jlo  (jlo_nxt),
        .jhi  (jhi_nxt)
    );

    // Next-state and next-output logic; everything holds unless a transition or handshake changes it.
    always_comb begin
        state_d  = state_q;
        szx_d    = szx_q;
        szy_d    = szy_q;
        last_i_d = last_i_q;
        tup_d    = tup_q;
        valid_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_SETUP;
                    szx_d   = sz_x_i;
                    szy_d   = sz_y_i;
                end
            end
            ST_SETUP: begin
                last_i_d = ZW'(szx_q) + ZW'(szy_q) - ZW'(2);
                tup_d    = '0;
                if ((szx_q == '0) || (szy_q == '0)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d     = ST_RUN;
                    tup_d.first = 1'b1;
                    tup_d.last  = 1'b1;
                end
            end
            ST_RUN: begin
                if (fire) begin
                    if (tup_q.y < jhi_cur) begin
                        tup_d.y     = y_inc;
                        tup_d.x     = SZW'(tup_q.z - y_inc);
                        tup_d.first = (y_inc == jlo_cur);
                        tup_d.last  = (y_inc == jhi_cur);
                    end else if (tup_q.z == last_i_q) begin
                        state_d = ST_DONE;
                    end else begin
                        tup_d.z     = z_inc;
                        tup_d.y     = jlo_nxt;
                        tup_d.x     = SZW'(z_inc - jlo_nxt);
                        tup_d.first = 1'b1;
                        tup_d.last  = (jlo_nxt == jhi_nxt);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        valid_d = (state_d == ST_RUN);
        busy_d  = (state_d == ST_SETUP) || (state_d == ST_RUN);
        done_d  = (state_d == ST_DONE);
    end

    // State, size, index and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            szx_q    <= '0;
            szy_q    <= '0;
            last_i_q <= '0;
            tup_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            szx_q    <= szx_d;
            szy_q    <= szy_d;
            last_i_q <= last_i_d;
            tup_q    <= tup_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign valid_o  = valid_q;
    assign x_addr_o = tup_q.x;
    assign y_addr_o = SZW'(tup_q.y);
    assign y_i_o    = tup_q.y;
    assign z_addr_o = tup_q.z;
    assign first_o  = tup_q.first;
    assign last_o   = tup_q.last;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

`ifdef CONV_IDX_STATS_EN
    logic [15:0] stall_q;

    // Saturating count of back-pressured cycles in the current run, cleared at setup.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (state_q == ST_SETUP) begin
            stall_q <= '0;
        end else if (valid_q && !ready_i && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_conv_index_seq.sv
// Directed self-checking bench for conv_index_seq (CONV_IDX_STATS_EN adds the stall counter check).
module tb_conv_index_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] sz_x, sz_y;
    logic       ready;
    logic       valid, first, last, busy, done;
    logic [4:0] x_addr, y_addr;
    logic [5:0] y_i, z_addr;
`ifdef CONV_IDX_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    int q_z[$], q_y[$], q_x[$], q_f[$], q_l[$], q_ya[$];
    logic [31:0] q_hold[$];

    always #5 clk = ~clk;

    conv_index_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .sz_x_i   (sz_x),
        .sz_y_i   (sz_y),
        .ready_i  (ready),
        .valid_o  (valid),
        .x_addr_o (x_addr),
        .y_addr_o (y_addr),
        .y_i_o    (y_i),
        .z_addr_o (z_addr),
        .first_o  (first),
        .last_o   (last),
        .busy_o   (busy),
        .done_o   (done)
`ifdef CONV_IDX_STATS_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int z, input int y, input int x, input int f, input int l);
        return {13'd0, z[5:0], y[5:0], x[4:0], f[0], l[0]};
    endfunction

    // Called at #1 after a posedge while IDLE; returns #1 into the SETUP cycle.
    task automatic do_start(input int sx, input int sy);
        start = 1'b1;
        sz_x  = 5'(sx);
        sz_y  = 5'(sy);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Record accepted tuples; stall ready for stall_len cycles before tuple index stall_at.
    task automatic collect(input int stall_at, input int stall_len, input int stop_after, output bit got_done);
        int stalled = 0;
        int c_last  = -10;
        got_done = 1'b0;
        q_z.delete(); q_y.delete(); q_x.delete(); q_f.delete(); q_l.delete(); q_ya.delete(); q_hold.delete();
        for (int c = 0; c < 1200; c++) begin
            ready = !((q_z.size() == stall_at) && (stalled < stall_len));
            if (done) begin
                got_done = 1'b1;
                if (q_z.size() != 0) chk("done_lat", 32'(c - c_last), 32'd1);
                chk("done_state", {29'd0, valid, busy, done}, 32'b001);
                break;
            end
            if (valid) begin
                if (ready) begin
                    q_z.push_back(int'(z_addr)); q_y.push_back(int'(y_i)); q_x.push_back(int'(x_addr));
                    q_f.push_back(int'(first));  q_l.push_back(int'(last)); q_ya.push_back(int'(y_addr));
                    c_last = c;
                    if (stop_after != 0 && q_z.size() == stop_after) break;
                end else begin
                    stalled++;
                    q_hold.push_back(pk(int'(z_addr), int'(y_i), int'(x_addr), int'(first), int'(last)));
                end
            end
            @(posedge clk); #1;
        end
        ready = 1'b1;
    endtask

    task automatic run(input int sx, input int sy, input int stall_at, input int stall_len,
                       input int stop_after, input string tg);
        bit got_done;
        do_start(sx, sy);
        chk({tg, "_setup"}, {29'd0, valid, busy, done}, 32'b010);
        @(posedge clk); #1;
        chk({tg, "_lat"}, {31'd0, valid}, 32'd1);
        collect(stall_at, stall_len, stop_after, got_done);
        if (stop_after == 0) begin
            chk({tg, "_done_seen"}, {31'd0, got_done}, 32'd1);
            @(posedge clk); #1;
            chk({tg, "_idle"}, {29'd0, valid, busy, done}, 32'b000);
        end
    endtask

    task automatic check_c1(input string tg);
        int ez[6]  = '{0, 1, 1, 2, 2, 3};
        int ey[6]  = '{0, 0, 1, 0, 1, 1};
        int ex[6]  = '{0, 1, 0, 2, 1, 2};
        int ef[6]  = '{1, 1, 0, 1, 0, 1};
        int el[6]  = '{1, 0, 1, 0, 1, 1};
        chk({tg, "_n"}, 32'(q_z.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < q_z.size()) begin
                chk($sformatf("%s_t%0d", tg, i), pk(q_z[i], q_y[i], q_x[i], q_f[i], q_l[i]),
                    pk(ez[i], ey[i], ex[i], ef[i], el[i]));
                chk($sformatf("%s_ya%0d", tg, i), 32'(q_ya[i]), 32'(ey[i]));
            end
        end
    endtask

    initial begin
        int ymax, nf, nl, n;
        rst   = 1'b1;
        start = 1'b0;
        sz_x  = '0;
        sz_y  = '0;
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {11'd0, valid, busy, done, first, last, z_addr, y_i, x_addr},  32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: sz_x=3, sz_y=2, no back-pressure
        run(3, 2, -1, 0, 0, "c1");
        check_c1("c1");

        // 2: single-element vectors
        run(1, 1, -1, 0, 0, "c2");
        chk("c2_n", 32'(q_z.size()), 32'd1);
        if (q_z.size() > 0) chk("c2_t0", pk(q_z[0], q_y[0], q_x[0], q_f[0], q_l[0]), pk(0, 0, 0, 1, 1));

        // 3: back-pressure for 3 cycles on tuple 3
        run(3, 2, 2, 3, 0, "c3");
        check_c1("c3");
        chk("c3_nhold", 32'(q_hold.size()), 32'd3);
        foreach (q_hold[k]) chk($sformatf("c3_hold%0d", k), q_hold[k], pk(1, 1, 0, 0, 1));
`ifdef CONV_IDX_STATS_EN
        chk("c3_stall_cnt", 32'(stall_cnt), 32'd3);
`endif

        // 4: zero-length y
        do_start(5, 0);
        chk("c4_setup", {29'd0, valid, busy, done}, 32'b010);
        @(posedge clk); #1;
        chk("c4_done", {29'd0, valid, busy, done}, 32'b001);
        @(posedge clk); #1;
        chk("c4_idle", {29'd0, valid, busy, done}, 32'b000);

        // 5: maximum sizes
        run(31, 31, -1, 0, 0, "c5");
        n = q_z.size();
        chk("c5_n", 32'(n), 32'd961);
        ymax = 0; nf = 0; nl = 0;
        foreach (q_y[k]) begin
            if (q_y[k] > ymax) ymax = q_y[k];
            nf += q_f[k];
            nl += q_l[k];
        end
        chk("c5_ymax", 32'(ymax), 32'd30);
        chk("c5_nfirst", 32'(nf), 32'd61);
        chk("c5_nlast", 32'(nl), 32'd61);
        if (n > 0) chk("c5_final", pk(q_z[n-1], q_y[n-1], q_x[n-1], q_f[n-1], q_l[n-1]), pk(60, 30, 30, 1, 1));

        // 6: reset mid-run after 4th tuple, then a clean rerun
        run(3, 2, -1, 0, 4, "c6");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("c6_rst_outs", {11'd0, valid, busy, done, first, last, z_addr, y_i, x_addr}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("c6_no_done", {31'd0, done}, 32'd0);
        run(3, 2, -1, 0, 0, "c6b");
        check_c1("c6b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
